// File: rtl/alu_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcodes and arbiter FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        SLT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters; unlisted codes fall back to ADD.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ALUOut,
    output logic                  eq
);

    always_comb begin
        ALUOut = ALUop1 + ALUop2;
        case (alu_op_e'(ALUctrl))
            SUB:     ALUOut = ALUop1 - ALUop2;
            AND:     ALUOut = ALUop1 & ALUop2;
            OR:      ALUOut = ALUop1 | ALUop2;
            SLT:     ALUOut = {{(DATA_WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
            default: ALUOut = ALUop1 + ALUop2;
        endcase
    end

    assign eq = (ALUop1 == ALUop2);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with registered
// operands and result. state | meaning: IDLE accept | EXEC compute | RESP hold.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    input  logic [5:0]              req_ctrl,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic                    rsp_eq,
    output logic                    busy
);

    arb_state_e            state_q;
    logic                  last_grant_q;
    logic                  grant_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  eq_q;
    logic [1:0]            rsp_valid_q;

    logic                  gnt_d;
    logic                  accept_d;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_eq;

    // On a tie the requester not served last wins, so grants alternate.
    always_comb begin
        case (req_valid)
            2'b01:   gnt_d = 1'b0;
            2'b10:   gnt_d = 1'b1;
            2'b11:   gnt_d = ~last_grant_q;
            default: gnt_d = 1'b0;
        endcase
        accept_d  = (state_q == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (accept_d) begin
            req_ready[gnt_d] = 1'b1;
        end
    end

    alu_share_arbiter_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .ALUop1 (op1_q),
        .ALUop2 (op2_q),
        .ALUctrl(ctrl_q),
        .ALUOut (alu_out),
        .eq     (alu_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            eq_q         <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        grant_q <= gnt_d;
                        op1_q   <= gnt_d ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : req_op1[DATA_WIDTH-1:0];
                        op2_q   <= gnt_d ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : req_op2[DATA_WIDTH-1:0];
                        ctrl_q  <= gnt_d ? req_ctrl[5:3] : req_ctrl[2:0];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_out;
                    eq_q        <= alu_eq;
                    rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        last_grant_q <= grant_q;
                        rsp_valid_q  <= 2'b00;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_eq     = eq_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: handshake timing, arbitration, ALU ops, reset.
module tb_alu_share_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [2*DW-1:0] req_op1 = '0;
    logic [2*DW-1:0] req_op2 = '0;
    logic [5:0]    req_ctrl = '0;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = '0;
    logic [DW-1:0] rsp_result;
    logic          rsp_eq;
    logic          busy;

    int tests = 0;
    int fails = 0;

    alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_eq(rsp_eq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c);
        req_op1[r*DW +: DW] = a;
        req_op2[r*DW +: DW] = b;
        req_ctrl[r*3 +: 3]  = c;
    endtask

    // Waits (bounded) for any req_ready bit; returns 0 on timeout.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic [31:0] er, input logic ee,
                          input string tag);
        bit ok;
        logic [1:0] oh;
        oh = 2'b01 << r;
        set_req(r, a, b, c);
        req_valid[r] = 1'b1;
        wait_ready(ok);
        if (!ok) chk({tag, "_accept_timeout"}, {62'd0, req_ready}, {62'd0, oh});
        else     chk({tag, "_req_ready"}, {62'd0, req_ready}, {62'd0, oh});
        tick();
        req_valid[r] = 1'b0;
        chk({tag, "_exec_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, "_exec_busy"}, {63'd0, busy}, 64'd1);
        tick();
        chk({tag, "_rsp_valid"}, {62'd0, rsp_valid}, {62'd0, oh});
        chk({tag, "_result"}, {32'd0, rsp_result}, {32'd0, er});
        chk({tag, "_eq"}, {63'd0, rsp_eq}, {63'd0, ee});
        rsp_ready[r] = 1'b1;
        tick();
        rsp_ready[r] = 1'b0;
        chk({tag, "_rsp_done"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bit ok;
        int k0, k1, g;
        logic [31:0] exp_res;

        // 1. reset state and first op latency
        do_reset();
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_eq", {63'd0, rsp_eq}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        run_op(0, 32'd7, 32'd5, 3'd1, 32'd2, 1'b0, "t1_sub");

        // 2. both requesters continuously valid: grants alternate from 0
        do_reset();
        k0 = 0; k1 = 0; g = 0;
        set_req(0, 32'd10, 32'd1, 3'd0);
        set_req(1, 32'd50, 32'd0, 3'd1);
        req_valid = 2'b11;
        for (int n = 0; n < 8; n++) begin
            wait_ready(ok);
            chk("t2_grant", {62'd0, req_ready}, {62'd0, (2'b01 << g)});
            exp_res = (g == 0) ? 32'd11 + k0 : 32'd50 - k1;
            tick();
            if (g == 0) begin
                k0++;
                set_req(0, 32'd10 + k0, 32'd1, 3'd0);
                if (k0 == 4) req_valid[0] = 1'b0;
            end else begin
                k1++;
                set_req(1, 32'd50, k1, 3'd1);
                if (k1 == 4) req_valid[1] = 1'b0;
            end
            tick();
            chk("t2_rsp_valid", {62'd0, rsp_valid}, {62'd0, (2'b01 << g)});
            chk("t2_result", {32'd0, rsp_result}, {32'd0, exp_res});
            rsp_ready = 2'b11;
            tick();
            rsp_ready = 2'b00;
            g = 1 - g;
        end

        // 3. response stalled 5 cycles; other requester and its rsp_ready ignored
        set_req(0, 32'h1234, 32'h1234, 3'd3);
        req_valid[0] = 1'b1;
        wait_ready(ok);
        chk("t3_req_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid[1] = 1'b1;
        set_req(1, 32'd1, 32'd2, 3'd0);
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_rsp_valid", {62'd0, rsp_valid}, 64'd1);
            chk("t3_hold_result", {32'd0, rsp_result}, 64'h1234);
            chk("t3_hold_eq", {63'd0, rsp_eq}, 64'd1);
            chk("t3_hold_req_ready", {62'd0, req_ready}, 64'd0);
            chk("t3_hold_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        req_valid[1] = 1'b0;
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("t3_rsp_done", {62'd0, rsp_valid}, 64'd0);

        // 4. SLT unsigned, AND with eq, undefined codes execute as ADD
        run_op(0, 32'd3, 32'hFFFF_FFFF, 3'd5, 32'd1, 1'b0, "t4_slt");
        run_op(1, 32'hA5, 32'hA5, 3'd2, 32'hA5, 1'b1, "t4_and");
        run_op(0, 32'd10, 32'd20, 3'd6, 32'd30, 1'b0, "t4_code6");
        run_op(1, 32'd5, 32'd5, 3'd4, 32'd10, 1'b1, "t4_code4");
        run_op(0, 32'd8, 32'd9, 3'd7, 32'd17, 1'b0, "t4_code7");

        // 5. wrap-around
        run_op(0, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 1'b0, "t5_add_wrap");
        run_op(1, 32'd0, 32'd1, 3'd1, 32'hFFFF_FFFF, 1'b0, "t5_sub_wrap");

        // 6. reset during EXEC discards the op
        set_req(0, 32'd40, 32'd2, 3'd0);
        req_valid[0] = 1'b1;
        wait_ready(ok);
        chk("t6_req_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("t6_exec_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_result", {32'd0, rsp_result}, 64'd0);
        chk("t6_rst_eq", {63'd0, rsp_eq}, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_rsp", {62'd0, rsp_valid}, 64'd0);
            chk("t6_idle", {63'd0, busy}, 64'd0);
        end
        run_op(1, 32'd8, 32'd3, 3'd1, 32'd5, 1'b0, "t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
